// File: rtl/string_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : string_transmitter
// Purpose  : Serial transmitter for the POV link; sends an 11-character,
//            7-bit-per-character string as start/data/parity/stop frames.
// Revision : 1.0 - initial release
// ============================================================================
module string_transmitter #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [0:76] String,
    output logic        txd,
    output logic        busy,
    output logic        done,
    output logic [3:0]  char_index
);

    localparam int                  c_BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_MAX  = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic                c_PAR_SEED  = (PARITY_ODD != 0);
    localparam logic [3:0]          c_LAST_CHAR = 4'd10;
    localparam logic [2:0]          c_LAST_BIT  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state, w_state_next;
    logic [c_BAUD_W-1:0]   r_baud, w_baud_next;
    logic [2:0]            r_bit_idx, w_bit_next;
    logic [3:0]            r_char_index, w_char_next;
    logic [0:76]           r_shadow, w_shadow_next;
    logic                  r_txd, w_txd_next;
    logic                  r_busy, w_busy_next;
    logic                  r_done, w_done_next;
    logic [6:0]            w_char;
    logic                  w_tick;

    // Current character, w_char[6] = ASCII bit 6 (the lowest string index).
    always_comb begin
        w_char = '0;
        for (int k = 0; k < 11; k++) begin
            if (r_char_index == 4'(k)) begin
                w_char = r_shadow[7*k +: 7];
            end
        end
    end

    assign w_tick = (r_baud == c_BAUD_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_baud       <= '0;
            r_bit_idx    <= '0;
            r_char_index <= '0;
            r_shadow     <= '0;
            r_txd        <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_baud       <= w_baud_next;
            r_bit_idx    <= w_bit_next;
            r_char_index <= w_char_next;
            r_shadow     <= w_shadow_next;
            r_txd        <= w_txd_next;
            r_busy       <= w_busy_next;
            r_done       <= w_done_next;
        end
    end

    // txd is computed one cycle ahead so the line itself comes straight from a flop.
    always_comb begin
        w_state_next  = r_state;
        w_baud_next   = w_tick ? '0 : r_baud + c_BAUD_W'(1);
        w_bit_next    = r_bit_idx;
        w_char_next   = r_char_index;
        w_shadow_next = r_shadow;
        w_txd_next    = r_txd;
        w_busy_next   = r_busy;
        w_done_next   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_baud_next = '0;
                w_txd_next  = 1'b1;
                w_busy_next = 1'b0;
                w_char_next = '0;
                if (start) begin
                    w_shadow_next = String;
                    w_state_next  = S_START;
                    w_txd_next    = 1'b0;
                    w_busy_next   = 1'b1;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_state_next = S_DATA;
                    w_bit_next   = '0;
                    w_txd_next   = w_char[0];
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == c_LAST_BIT) begin
                        w_state_next = S_PARITY;
                        w_txd_next   = (^w_char) ^ c_PAR_SEED;
                    end else begin
                        w_bit_next = r_bit_idx + 3'd1;
                        w_txd_next = w_char[r_bit_idx + 3'd1];
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_state_next = S_STOP;
                    w_txd_next   = 1'b1;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_char_index == c_LAST_CHAR) begin
                        w_state_next = S_IDLE;
                        w_busy_next  = 1'b0;
                        w_done_next  = 1'b1;
                        w_char_next  = '0;
                        w_txd_next   = 1'b1;
                    end else begin
                        w_state_next = S_START;
                        w_char_next  = r_char_index + 4'd1;
                        w_txd_next   = 1'b0;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_txd_next   = 1'b1;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    assign txd        = r_txd;
    assign busy       = r_busy;
    assign done       = r_done;
    assign char_index = r_char_index;

endmodule
`default_nettype wire

// File: tb/tb_string_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_string_transmitter
// Purpose  : Directed self-checking bench for string_transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_string_transmitter;

    localparam int c_N16 = 16;
    localparam int c_N4  = 4;

    logic        clk;
    logic        reset;
    logic        start0, start1, start2;
    logic [0:76] str0, str1, str2;
    logic        txd0, txd1, txd2;
    logic        busy0, busy1, busy2;
    logic        done0, done1, done2;
    logic [3:0]  idx0, idx1, idx2;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          sel      = 0;
    int          busy_cnt = 0;
    int          done_cnt = 0;

    logic        txd_s, busy_s, done_s;
    logic [3:0]  idx_s;

    string_transmitter #(.CLKS_PER_BIT(c_N16), .PARITY_ODD(0)) u_dut16 (
        .clk(clk), .reset(reset), .start(start0), .String(str0),
        .txd(txd0), .busy(busy0), .done(done0), .char_index(idx0)
    );
    string_transmitter #(.CLKS_PER_BIT(c_N4), .PARITY_ODD(0)) u_dut4e (
        .clk(clk), .reset(reset), .start(start1), .String(str1),
        .txd(txd1), .busy(busy1), .done(done1), .char_index(idx1)
    );
    string_transmitter #(.CLKS_PER_BIT(c_N4), .PARITY_ODD(1)) u_dut4o (
        .clk(clk), .reset(reset), .start(start2), .String(str2),
        .txd(txd2), .busy(busy2), .done(done2), .char_index(idx2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        txd_s  = txd0;
        busy_s = busy0;
        done_s = done0;
        idx_s  = idx0;
        case (sel)
            1: begin txd_s = txd1; busy_s = busy1; done_s = done1; idx_s = idx1; end
            2: begin txd_s = txd2; busy_s = busy2; done_s = done2; idx_s = idx2; end
            default: ;
        endcase
    end

    always @(negedge clk) begin
        if (busy0) busy_cnt++;
        if (done0) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [0:76] pack(input string s);
        logic [0:76] v;
        byte         c;
        v = '0;
        for (int k = 0; k < 11; k++) begin
            c = s.getc(k);
            v[7*k +: 7] = c[6:0];
        end
        return v;
    endfunction

    function automatic logic [6:0] chr(input string s, input int k);
        byte c;
        c = s.getc(k);
        return c[6:0];
    endfunction

    // Every cycle of a frame against a hand-written table, first bit in seq[9].
    task automatic hold_frame(input int n, input logic [9:0] seq, input string tag);
        for (int j = 0; j < 10; j++) begin
            for (int c = 0; c < n; c++) begin
                check(tag, 32'(txd_s), 32'(seq[9-j]));
                tick();
            end
        end
    endtask

    // Mid-bit UART decoder; entered one step after the edge that begins the start bit.
    task automatic rx_frame(input int n, input int k, input logic [6:0] exp_ch,
                            input logic odd, input logic poke);
        logic [6:0] ch;
        logic       p;
        repeat (n/2) tick();
        check("start_bit", 32'(txd_s), 32'd0);
        check("char_index", 32'(idx_s), 32'(k));
        if (poke) begin
            start0 = 1'b1;
            str0   = pack("XXXXXXXXXXX");
        end
        for (int b = 0; b < 7; b++) begin
            repeat (n) tick();
            ch[b] = txd_s;
            if (poke && b == 0) start0 = 1'b0;
        end
        repeat (n) tick();
        p = txd_s;
        repeat (n) tick();
        check("stop_bit", 32'(txd_s), 32'd1);
        repeat (n - n/2) tick();
        check("char", 32'(ch), 32'(exp_ch));
        check("parity", 32'(p), 32'((^exp_ch) ^ odd));
    endtask

    initial begin : main
        string hw, gb;
        int    bb, db;
        hw = "HELLO WORLD";
        gb = "GOODBYE SKY";
        reset  = 1'b1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        str0 = pack(hw); str1 = pack(hw); str2 = pack(hw);
        repeat (3) tick();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("rst_txd",  32'(txd_s),  32'd1);
            check("rst_busy", 32'(busy_s), 32'd0);
            check("rst_done", 32'(done_s), 32'd0);
            check("rst_idx",  32'(idx_s),  32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();

        // 'A' even parity at 4 clocks per bit
        sel  = 1;
        str1 = pack("ABCDEFGHIJK");
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("a_busy", 32'(busy_s), 32'd1);
        check("a_idx",  32'(idx_s),  32'd0);
        hold_frame(c_N4, 10'b0100000101, "frame_A");

        // 'C' odd parity at 4 clocks per bit
        sel  = 2;
        str2 = pack("CDEFGHIJKLM");
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        hold_frame(c_N4, 10'b0110000101, "frame_C_odd");

        // Full message
        sel = 0;
        bb = busy_cnt; db = done_cnt;
        str0 = pack(hw);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int k = 0; k < 11; k++) rx_frame(c_N16, k, chr(hw, k), 1'b0, 1'b0);
        check("end_done", 32'(done_s), 32'd1);
        check("end_busy", 32'(busy_s), 32'd0);
        check("end_txd",  32'(txd_s),  32'd1);
        check("end_idx",  32'(idx_s),  32'd0);
        tick();
        check("done_width", 32'(done_s), 32'd0);
        repeat (4) tick();
        check("busy_cycles", 32'(busy_cnt - bb), 32'd1760);
        check("done_pulses", 32'(done_cnt - db), 32'd1);

        // start and String change during character 5 must be ignored
        bb = busy_cnt; db = done_cnt;
        str0 = pack(hw);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int k = 0; k < 11; k++) rx_frame(c_N16, k, chr(hw, k), 1'b0, k == 5);
        check("ign_done", 32'(done_s), 32'd1);
        repeat (5*c_N16) tick();
        check("ign_busy_cycles", 32'(busy_cnt - bb), 32'd1760);
        check("ign_done_pulses", 32'(done_cnt - db), 32'd1);
        check("ign_idle_busy",   32'(busy_s), 32'd0);
        check("ign_idle_txd",    32'(txd_s),  32'd1);

        // start held high: second message one cycle after done, new string
        str0 = pack(hw);
        start0 = 1'b1;
        tick();
        str0 = pack(gb);
        for (int k = 0; k < 11; k++) rx_frame(c_N16, k, chr(hw, k), 1'b0, 1'b0);
        check("b2b_done", 32'(done_s), 32'd1);
        check("b2b_busy", 32'(busy_s), 32'd0);
        check("b2b_txd",  32'(txd_s),  32'd1);
        tick();
        check("b2b_restart_txd",  32'(txd_s),  32'd0);
        check("b2b_restart_busy", 32'(busy_s), 32'd1);
        check("b2b_restart_done", 32'(done_s), 32'd0);
        start0 = 1'b0;
        for (int k = 0; k < 11; k++) rx_frame(c_N16, k, chr(gb, k), 1'b0, 1'b0);
        check("b2b2_done", 32'(done_s), 32'd1);
        repeat (3) tick();

        // Asynchronous reset in the first data bit of character 3 ('L', bit0 = 0)
        str0 = pack(hw);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int k = 0; k < 3; k++) rx_frame(c_N16, k, chr(hw, k), 1'b0, 1'b0);
        repeat (c_N16 + c_N16/2) tick();
        check("pre_rst_txd", 32'(txd_s), 32'd0);
        check("pre_rst_idx", 32'(idx_s), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("arst_txd",  32'(txd_s),  32'd1);
        check("arst_busy", 32'(busy_s), 32'd0);
        check("arst_done", 32'(done_s), 32'd0);
        check("arst_idx",  32'(idx_s),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        db = done_cnt;
        repeat (3*c_N16) tick();
        check("post_rst_done", 32'(done_cnt - db), 32'd0);
        check("post_rst_busy", 32'(busy_s), 32'd0);
        check("post_rst_txd",  32'(txd_s),  32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
